// File: rtl/register_file_mp.sv
// register_file_mp: multi-port integer register file with a per-register scoreboard.
//
// Register 0 reads as zero and is never busy. Writes and allocs to index 0, or to any index
// >= NREGS, are dropped. Reads of such indices return 0 and not-busy.
//
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle writeback data to the read
// ports. Default build (macro undefined) returns registered state only.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset (clears data, busy bits and busy count)
//   rd_addr    read index per read port
//   rd_data    read data per read port (combinational)
//   rd_busy    1 = register read by that port has an outstanding producer
//   wr_en      writeback enable per write port
//   wr_addr    writeback destination per write port
//   wr_data    writeback data per write port
//   alloc_en   issue marks alloc_reg as pending
//   alloc_reg  register being allocated
//   busy_cnt   number of registers currently busy
module register_file_mp #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREGS  = 32,
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned NUM_WR = 2,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_RD-1:0][AW-1:0]      rd_addr,
  output logic [NUM_RD-1:0][XLEN-1:0]    rd_data,
  output logic [NUM_RD-1:0]              rd_busy,
  input  logic [NUM_WR-1:0]              wr_en,
  input  logic [NUM_WR-1:0][AW-1:0]      wr_addr,
  input  logic [NUM_WR-1:0][XLEN-1:0]    wr_data,
  input  logic                           alloc_en,
  input  logic [AW-1:0]                  alloc_reg,
  output logic [AW:0]                    busy_cnt
);

  // Register 0 has no storage at all.
  logic [XLEN-1:0]  regs_q [NREGS-1:1];
  logic [XLEN-1:0]  regs_d [NREGS-1:1];
  logic [NREGS-1:1] busy_q, busy_d;
  logic [AW:0]      busy_cnt_q, busy_cnt_d;

  // Next-state: writes in ascending port order so the highest port wins; alloc applied last so
  // a new producer outranks a same-cycle writeback. The counter follows each busy transition.
  always_comb begin
    busy_cnt_d = busy_cnt_q;
    for (int i = 1; i < int'(NREGS); i++) begin
      regs_d[i] = regs_q[i];
      busy_d[i] = busy_q[i];
      for (int w = 0; w < int'(NUM_WR); w++) begin
        if (wr_en[w] && (wr_addr[w] == AW'(i))) begin
          regs_d[i] = wr_data[w];
          busy_d[i] = 1'b0;
        end
      end
      if (alloc_en && (alloc_reg == AW'(i))) begin
        busy_d[i] = 1'b1;
      end
      if (busy_d[i] && !busy_q[i]) begin
        busy_cnt_d = busy_cnt_d + (AW+1)'(1);
      end else if (!busy_d[i] && busy_q[i]) begin
        busy_cnt_d = busy_cnt_d - (AW+1)'(1);
      end
    end
    if (rst) begin
      for (int i = 1; i < int'(NREGS); i++) begin
        regs_d[i] = '0;
      end
      busy_d     = '0;
      busy_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    regs_q     <= regs_d;
    busy_q     <= busy_d;
    busy_cnt_q <= busy_cnt_d;
  end

  // Set when the read index names a real, nonzero register.
  logic [NUM_RD-1:0] rd_valid;

  always_comb begin
    for (int p = 0; p < int'(NUM_RD); p++) begin
      rd_data[p]  = '0;
      rd_busy[p]  = 1'b0;
      rd_valid[p] = 1'b0;
      for (int i = 1; i < int'(NREGS); i++) begin
        if (rd_addr[p] == AW'(i)) begin
          rd_data[p]  = regs_q[i];
          rd_busy[p]  = busy_q[i];
          rd_valid[p] = 1'b1;
        end
      end
`ifdef REGFILE_BYPASS_EN
      if (!rst && rd_valid[p]) begin
        for (int w = 0; w < int'(NUM_WR); w++) begin
          if (wr_en[w] && (wr_addr[w] == rd_addr[p])) begin
            rd_data[p] = wr_data[w];
            rd_busy[p] = alloc_en && (alloc_reg == rd_addr[p]);
          end
        end
      end
`endif
    end
  end

  assign busy_cnt = busy_cnt_q;

endmodule

// File: tb/tb_register_file_mp.sv
module tb_register_file_mp;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned NREGS  = 32;
  localparam int unsigned NUM_RD = 2;
  localparam int unsigned NUM_WR = 2;
  localparam int unsigned AW     = $clog2(NREGS);

  logic                        clk = 1'b0;
  logic                        rst;
  logic [NUM_RD-1:0][AW-1:0]   rd_addr;
  logic [NUM_RD-1:0][XLEN-1:0] rd_data;
  logic [NUM_RD-1:0]           rd_busy;
  logic [NUM_WR-1:0]           wr_en;
  logic [NUM_WR-1:0][AW-1:0]   wr_addr;
  logic [NUM_WR-1:0][XLEN-1:0] wr_data;
  logic                        alloc_en;
  logic [AW-1:0]               alloc_reg;
  logic [AW:0]                 busy_cnt;

  register_file_mp #(
    .XLEN   (XLEN),
    .NREGS  (NREGS),
    .NUM_RD (NUM_RD),
    .NUM_WR (NUM_WR)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_busy   (rd_busy),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .alloc_en  (alloc_en),
    .alloc_reg (alloc_reg),
    .busy_cnt  (busy_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  // Reference state: architectural contents and pending flags.
  logic [XLEN-1:0] m_regs [NREGS];
  bit              m_busy [NREGS];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic bit addr_ok(input int a);
    return (a != 0) && (a < int'(NREGS));
  endfunction

  function automatic logic [XLEN-1:0] exp_data(input int p);
    int a = int'(rd_addr[p]);
    logic [XLEN-1:0] r;
    if (!addr_ok(a)) return '0;
    r = m_regs[a];
`ifdef REGFILE_BYPASS_EN
    if (!rst)
      for (int w = 0; w < int'(NUM_WR); w++)
        if (wr_en[w] && int'(wr_addr[w]) == a) r = wr_data[w];
`endif
    return r;
  endfunction

  function automatic bit exp_busy(input int p);
    int a = int'(rd_addr[p]);
    bit b;
    if (!addr_ok(a)) return 1'b0;
    b = m_busy[a];
`ifdef REGFILE_BYPASS_EN
    if (!rst)
      for (int w = 0; w < int'(NUM_WR); w++)
        if (wr_en[w] && int'(wr_addr[w]) == a) b = alloc_en && (int'(alloc_reg) == a);
`endif
    return b;
  endfunction

  function automatic int popcount_busy();
    int c = 0;
    for (int i = 0; i < int'(NREGS); i++) c += int'(m_busy[i]);
    return c;
  endfunction

  // Apply the edge that just happened to the reference state.
  task automatic model_update();
    if (rst) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        m_regs[i] = '0;
        m_busy[i] = 1'b0;
      end
    end else begin
      for (int w = 0; w < int'(NUM_WR); w++)
        if (wr_en[w] && addr_ok(int'(wr_addr[w]))) begin
          m_regs[wr_addr[w]] = wr_data[w];
          m_busy[wr_addr[w]] = 1'b0;
        end
      if (alloc_en && addr_ok(int'(alloc_reg))) m_busy[alloc_reg] = 1'b1;
    end
  endtask

  // Single compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int p = 0; p < int'(NUM_RD); p++) begin
        check($sformatf("rd_data[%0d]", p), 64'(rd_data[p]), 64'(exp_data(p)));
        check($sformatf("rd_busy[%0d]", p), 64'(rd_busy[p]), 64'(exp_busy(p)));
      end
      check("busy_cnt", 64'(busy_cnt), 64'(popcount_busy()));
    end
  end

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    rst       = 1'b0;
    wr_en     = '0;
    wr_addr   = '0;
    wr_data   = '0;
    alloc_en  = 1'b0;
    alloc_reg = '0;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  logic [XLEN-1:0] x2_same;

  initial begin
    idle();
    rst     = 1'b1;
    rd_addr = '0;
    for (int i = 0; i < int'(NREGS); i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
    tick();
    cmp_en = 1'b1;
    tick();
    idle();

    // Reset clears data, busy and count.
    wr_en[0] = 1'b1; wr_addr[0] = 5; wr_data[0] = 32'hDEAD; alloc_en = 1'b1; alloc_reg = 5;
    tick();
    idle();
    rd_addr[0] = 5;
    at_neg();
    check("x5 before reset", 64'(rd_data[0]), 64'h0000_DEAD);
    check("cnt before reset", 64'(busy_cnt), 64'd1);
    rst = 1'b1;
    tick();
    idle();
    at_neg();
    check("x5 after reset", 64'(rd_data[0]), 64'd0);
    check("x5 busy after reset", 64'(rd_busy[0]), 64'd0);
    check("cnt after reset", 64'(busy_cnt), 64'd0);

    // x0 stays zero and never busy.
    wr_en[0] = 1'b1; wr_addr[0] = 0; wr_data[0] = 32'hFFFF_FFFF; alloc_en = 1'b1; alloc_reg = 0;
    tick();
    idle();
    rd_addr[0] = 0;
    at_neg();
    check("x0 data", 64'(rd_data[0]), 64'd0);
    check("x0 busy", 64'(rd_busy[0]), 64'd0);
    check("x0 cnt", 64'(busy_cnt), 64'd0);

    // Scoreboard.
    alloc_en = 1'b1; alloc_reg = 3;
    tick();
    alloc_reg = 7;
    tick();
    idle();
    at_neg();
    check("cnt two allocs", 64'(busy_cnt), 64'd2);
    wr_en[1] = 1'b1; wr_addr[1] = 3; wr_data[1] = 32'h1234;
    tick();
    idle();
    rd_addr[0] = 3;
    at_neg();
    check("x3 busy cleared", 64'(rd_busy[0]), 64'd0);
    check("cnt after write", 64'(busy_cnt), 64'd1);
    check("x3 data", 64'(rd_data[0]), 64'h1234);

    // Write conflict: port 1 wins.
    wr_en = 2'b11; wr_addr[0] = 9; wr_addr[1] = 9; wr_data[0] = 32'hAAAA; wr_data[1] = 32'hBBBB;
    tick();
    idle();
    rd_addr[1] = 9;
    at_neg();
    check("x9 conflict", 64'(rd_data[1]), 64'hBBBB);

    // Alloc + write same cycle on already-busy x4.
    alloc_en = 1'b1; alloc_reg = 4;
    tick();
    idle();
    at_neg();
    check("cnt x4 alloc", 64'(busy_cnt), 64'd2);
    alloc_en = 1'b1; alloc_reg = 4; wr_en[0] = 1'b1; wr_addr[0] = 4; wr_data[0] = 32'h4444;
    tick();
    idle();
    rd_addr[0] = 4;
    at_neg();
    check("x4 data", 64'(rd_data[0]), 64'h4444);
    check("x4 busy", 64'(rd_busy[0]), 64'd1);
    check("x4 cnt", 64'(busy_cnt), 64'd2);

    // Same-cycle visibility of a write.
    wr_en[0] = 1'b1; wr_addr[0] = 2; wr_data[0] = 32'h11;
    tick();
    idle();
    rd_addr[1] = 2;
    wr_en[0] = 1'b1; wr_addr[0] = 2; wr_data[0] = 32'h55;
    at_neg();
`ifdef REGFILE_BYPASS_EN
    x2_same = 32'h55;
`else
    x2_same = 32'h11;
`endif
    check("x2 same cycle", 64'(rd_data[1]), 64'(x2_same));
    check("x2 busy same cycle", 64'(rd_busy[1]), 64'd0);
    tick();
    idle();
    at_neg();
    check("x2 next cycle", 64'(rd_data[1]), 64'h55);

    // Randomized traffic, biased toward a few registers to provoke conflicts.
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      for (int w = 0; w < int'(NUM_WR); w++) begin
        wr_en[w]   = $urandom_range(0, 1);
        wr_addr[w] = $urandom_range(0, 1) ? AW'($urandom_range(0, 5)) : AW'($urandom);
        wr_data[w] = $urandom;
      end
      alloc_en  = ($urandom_range(0, 2) != 0);
      alloc_reg = $urandom_range(0, 1) ? AW'($urandom_range(0, 5)) : AW'($urandom);
      for (int p = 0; p < int'(NUM_RD); p++)
        rd_addr[p] = $urandom_range(0, 1) ? AW'($urandom_range(0, 5)) : AW'($urandom);
      tick();
    end
    idle();
    at_neg();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
